// File: rtl/mem_pkg.sv
// Shared encodings for the CPU-to-memory access controller: access sizes,
// controller states and the alignment rule.
package mem_pkg;

   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_BYTE = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } state_t;

   // True when the request can never reach memory: illegal size or misaligned.
   function automatic logic access_bad(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      case (size)
         SZ_WORD: bad = (offset != 2'b00);
         SZ_HALF: bad = offset[0];
         SZ_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_encode.sv
// Byte-lane write-enable mask and lane positioning of right-justified store data.
module mem_lane_encode
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   output logic [3:0]  lane_mask,
   output logic [31:0] lane_data
);

   always_comb begin
      lane_mask = 4'b0000;
      lane_data = 32'h0000_0000;
      case (size)
         SZ_WORD: begin
            lane_mask = 4'b1111;
            lane_data = wdata;
         end
         SZ_HALF: begin
            if (offset[1]) begin
               lane_mask = 4'b1100;
               lane_data = {wdata[15:0], 16'h0000};
            end else begin
               lane_mask = 4'b0011;
               lane_data = {16'h0000, wdata[15:0]};
            end
         end
         SZ_BYTE: begin
            lane_mask = 4'b0001 << offset;
            lane_data = {24'h00_0000, wdata[7:0]} << {offset, 3'b000};
         end
         default: begin
            lane_mask = 4'b0000;
            lane_data = 32'h0000_0000;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding CPU load/store controller: alignment check, lane steering,
// mem_ready timeout and sign/zero extension of load results.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_sext,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_stall,
   output logic        cpu_err,
   output logic        mem_en,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  fsm_state
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  tmo_cnt;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        we_q;
   logic        sext_q;
   logic [3:0]  lane_mask;
   logic [31:0] lane_data;
   logic [31:0] shifted;
   logic [31:0] load_val;

   mem_lane_encode u_lane (
      .size      (cpu_size),
      .offset    (cpu_addr[1:0]),
      .wdata     (cpu_wdata),
      .lane_mask (lane_mask),
      .lane_data (lane_data)
   );

   // Right-justify the addressed lane(s), then extend to 32 bits.
   always_comb begin
      shifted  = mem_rdata >> {off_q, 3'b000};
      load_val = shifted;
      case (size_q)
         SZ_BYTE: load_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   assign cpu_stall = cpu_req & ~cpu_done;
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tmo_cnt   <= 8'd0;
         off_q     <= 2'b00;
         size_q    <= SZ_WORD;
         we_q      <= 1'b0;
         sext_q    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 4'b0000;
         mem_addr  <= 32'h0000_0000;
         mem_wdata <= 32'h0000_0000;
         cpu_done  <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= 32'h0000_0000;
      end else begin
         cpu_done <= 1'b0;
         cpu_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  off_q   <= cpu_addr[1:0];
                  size_q  <= cpu_size;
                  we_q    <= cpu_we;
                  sext_q  <= cpu_sext;
                  tmo_cnt <= 8'd0;
                  if (access_bad(cpu_size, cpu_addr[1:0])) begin
                     state    <= ERR;
                     cpu_done <= 1'b1;
                     cpu_err  <= 1'b1;
                  end else begin
                     state     <= ACCESS;
                     mem_en    <= 1'b1;
                     mem_we    <= cpu_we ? lane_mask : 4'b0000;
                     mem_addr  <= {cpu_addr[31:2], 2'b00};
                     mem_wdata <= lane_data;
                  end
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  state    <= DONE;
                  cpu_done <= 1'b1;
                  mem_en   <= 1'b0;
                  mem_we   <= 4'b0000;
                  tmo_cnt  <= 8'd0;
                  if (!we_q) begin
                     cpu_rdata <= load_val;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  // The TIMEOUT-th cycle without mem_ready abandons the access.
                  state    <= ERR;
                  cpu_done <= 1'b1;
                  cpu_err  <= 1'b1;
                  mem_en   <= 1'b0;
                  mem_we   <= 4'b0000;
                  tmo_cnt  <= 8'd0;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
